ysyx_22040088_lsu: RTL
======================

// Module: ysyx_22040088_lsu
// PURPOSE
//  Load/store stage directly downstream of the execute stage. Accepts one instruction per valid/ready handshake:
//  - effective address = EXU alu_result
//  - store data = rf_rdata2
//  Runs a request/response transaction on a 64-bit data-memory port: byte-lane shifting, write masks, load sign/zero-extension.
//  Non-memory instructions pass alu_result through to write-back with one cycle of latency.
// PARAMETERS
//  XLEN   64  datapath width (fixed 64; address and data)
//  RD_W   5   destination register index width
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      asynchronous reset, active-high
//  in_valid     in   1      EXU presents an instruction
//  in_ready     out  1      LSU can accept (state==IDLE)
//  in_memop     in   5      [0]=load [1]=store [3:2]=size 00B/01H/10W/11D [4]=unsigned load
//  in_addr      in   XLEN   alu_result from EXU (address, or result for non-mem ops)
//  in_wdata     in   XLEN   store data (rf_rdata2)
//  in_rd        in   RD_W   destination register
//  in_rf_wen    in   1      instruction writes rd
//  req_valid    out  1      memory request valid
//  req_ready    in   1      memory accepts request
//  req_wen      out  1      1=write, 0=read
//  req_addr     out  XLEN   in_addr with [2:0] cleared
//  req_wdata    out  XLEN   store data shifted to byte lane
//  req_wmask    out  8      byte enables (0 for reads)
//  resp_valid   in   1      read/write completion; rdata valid this cycle
//  resp_rdata   in   XLEN   aligned 64-bit read data
//  out_valid    out  1      result to write-back valid
//  out_ready    in   1      write-back accepts
//  out_data     out  XLEN   write-back value
//  out_rd       out  RD_W   destination register
//  out_rf_wen   out  1      write enable to register file
//  out_misalign out  1      access was misaligned; no memory access performed
// BEHAVIOUR
//  - FSM states: IDLE, REQ, WAIT, DONE.
//  - Reset (async): state=IDLE. req_valid=0, out_valid=0, all other registered outputs 0.
//    Reset mid-transaction abandons it; a late resp_valid after reset is ignored (only sampled in WAIT).
//  - IDLE: in_ready=1. On in_valid, latch memop/addr/wdata/rd/rf_wen, then branch:
//    . neither load nor store          -> DONE; out_data=in_addr, out_rf_wen=in_rf_wen
//    . misaligned (addr%size!=0)       -> DONE; out_misalign=1, out_rf_wen=0, out_data=0
//    . otherwise                       -> REQ (load and store both set: treated as store)
//  - REQ: req_valid=1. req_* stable until req_ready. On req_ready -> WAIT.
//    resp_valid is not sampled in REQ; memory responds >=1 cycle after the request handshake.
//  - WAIT: on resp_valid -> DONE.
//    . load: lane = resp_rdata >> (8*addr[2:0]); truncate to size; sign-extend unless [4] set; out_rf_wen=in_rf_wen
//    . store: out_data=0, out_rf_wen=0
//  - DONE: out_valid=1, out_* held stable until out_ready; on out_ready -> IDLE (in_ready goes high next cycle; no same-cycle re-accept).
//  - Store lanes: wmask = {1,3,F,FF}[size] << addr[2:0]; wdata = in_wdata << (8*addr[2:0]); bytes outside mask don't care.
//  - Latency: accept at T -> bypass out_valid at T+1. Memory op with immediate req_ready and resp at T+2 -> out_valid at T+3.
//  - Throughput: one instruction in flight; in_ready=0 in REQ/WAIT/DONE.
// TESTING
//  1. Bypass: memop=0, addr=0x1234, rd=5, rf_wen=1 -> out_valid next cycle, out_data=0x1234, out_rd=5, out_rf_wen=1.
//  2. Load byte signed: addr=0x80000003, resp_rdata=0x00000000_80FF0000 ->
//     req_addr=0x80000000, req_wmask=0, out_data=0xFFFF_FFFF_FFFF_FF80. Same with unsigned -> 0x80.
//  3. Store half: addr=0x80000006, wdata=0xBEEF -> req_wen=1, req_wmask=0xC0,
//     req_wdata[63:48]=0xBEEF, out_rf_wen=0.
//  4. Misaligned: load W at addr=0x80000002 -> no req_valid ever, out_misalign=1, out_rf_wen=0.
//  5. Backpressure: req_ready low 3 cycles, then out_ready low 2 cycles -> req_*/out_* stable throughout,
//     in_ready=0 until the cycle after the out handshake.
//  6. Reset asserted in WAIT, stray resp_valid after release -> state IDLE, out_valid stays 0, next in_valid accepted normally.

Source files
------------

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit sitting after EXU: one instruction in flight, request/response
// data-memory port with byte-lane alignment, write masks and load extension.
module ysyx_22040088_lsu #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_memop,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_rf_wen,
  output logic            req_valid,
  input  logic            req_ready,
  output logic            req_wen,
  output logic [XLEN-1:0] req_addr,
  output logic [XLEN-1:0] req_wdata,
  output logic [7:0]      req_wmask,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RD_W-1:0] out_rd,
  output logic            out_rf_wen,
  output logic            out_misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [4:0]      r_memop;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [RD_W-1:0] r_rd;
  logic            r_rf_wen;
  logic [XLEN-1:0] r_out_data;
  logic            r_out_rf_wen;
  logic            r_out_misalign;

  logic            w_in_mem;
  logic            w_in_misalign;
  logic            w_is_store;
  logic [7:0]      w_size_mask;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_load_data;
  logic            w_unsigned;

  // Alignment is judged on the incoming address so the branch happens at accept.
  assign w_in_mem = in_memop[0] | in_memop[1];
  always_comb begin
    w_in_misalign = 1'b0;
    case (in_memop[3:2])
      2'b00:   w_in_misalign = 1'b0;
      2'b01:   w_in_misalign = in_addr[0];
      2'b10:   w_in_misalign = |in_addr[1:0];
      default: w_in_misalign = |in_addr[2:0];
    endcase
  end

  // A store bit wins over a load bit when both are set.
  assign w_is_store = r_memop[1];
  assign w_unsigned = r_memop[4];

  always_comb begin
    w_size_mask = 8'h00;
    case (r_memop[3:2])
      2'b00:   w_size_mask = 8'h01;
      2'b01:   w_size_mask = 8'h03;
      2'b10:   w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  assign w_lane = resp_rdata >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_load_data = '0;
    case (r_memop[3:2])
      2'b00:   w_load_data = {{56{w_lane[7]  & ~w_unsigned}}, w_lane[7:0]};
      2'b01:   w_load_data = {{48{w_lane[15] & ~w_unsigned}}, w_lane[15:0]};
      2'b10:   w_load_data = {{32{w_lane[31] & ~w_unsigned}}, w_lane[31:0]};
      default: w_load_data = w_lane;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_in_mem && !w_in_misalign) begin
            w_state_next = REQ;
          end else begin
            w_state_next = DONE;
          end
        end
      end
      REQ:     if (req_ready)  w_state_next = WAIT;
      WAIT:    if (resp_valid) w_state_next = DONE;
      default: if (out_ready)  w_state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == IDLE);
    req_valid = (r_state == REQ);
    out_valid = (r_state == DONE);
  end

  assign req_wen      = w_is_store;
  assign req_addr     = {r_addr[XLEN-1:3], 3'b000};
  assign req_wdata    = r_wdata << {r_addr[2:0], 3'b000};
  assign req_wmask    = w_is_store ? (w_size_mask << r_addr[2:0]) : 8'h00;
  assign out_data     = r_out_data;
  assign out_rd       = r_rd;
  assign out_rf_wen   = r_out_rf_wen;
  assign out_misalign = r_out_misalign;

  // Instruction latch and write-back result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_memop        <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rd           <= '0;
      r_rf_wen       <= 1'b0;
      r_out_data     <= '0;
      r_out_rf_wen   <= 1'b0;
      r_out_misalign <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_memop  <= in_memop;
        r_addr   <= in_addr;
        r_wdata  <= in_wdata;
        r_rd     <= in_rd;
        r_rf_wen <= in_rf_wen;
        if (!w_in_mem) begin
          r_out_data     <= in_addr;
          r_out_rf_wen   <= in_rf_wen;
          r_out_misalign <= 1'b0;
        end else if (w_in_misalign) begin
          r_out_data     <= '0;
          r_out_rf_wen   <= 1'b0;
          r_out_misalign <= 1'b1;
        end else begin
          r_out_data     <= '0;
          r_out_rf_wen   <= 1'b0;
          r_out_misalign <= 1'b0;
        end
      end else if (r_state == WAIT && resp_valid) begin
        if (w_is_store) begin
          r_out_data   <= '0;
          r_out_rf_wen <= 1'b0;
        end else begin
          r_out_data   <= w_load_data;
          r_out_rf_wen <= r_rf_wen;
        end
      end
    end
  end

endmodule
